wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port stallW  input  1  hold writeback pipeline register.
REQ-004 SHALL have port flushW  input  1  load a bubble into W on the next edge.
REQ-005 SHALL have port valid_m  input  1  MEM-stage instruction valid.
REQ-006 SHALL have port pc_m  input  32  MEM-stage PC.
REQ-007 SHALL have port reg_write_m  input  1  instruction writes a GPR.
REQ-008 SHALL have port wa_m  input  5  destination register.
REQ-009 SHALL have port result_m  input  32  ALU result, or load address for loads.
REQ-010 SHALL have port mem_to_reg_m  input  1  instruction is a load.
REQ-011 SHALL have port load_type_m  input  3  load kind, encoded per the package.
REQ-012 SHALL have port data_sram_rdata  input  32  synchronous SRAM read data, valid only in the first W cycle of a load.
REQ-013 SHALL have port we3  output  1  register-file write enable.
REQ-014 SHALL have port wa3  output  5  register-file write address.
REQ-015 SHALL have port wd3  output  32  register-file write data.
REQ-016 SHALL have port pc_w  output  32  W-stage PC.

Function
REQ-017 SHALL capture valid_m, pc_m, reg_write_m, wa_m, result_m, mem_to_reg_m and load_type_m into the W register on a posedge when stallW=0 and flushW=0.
REQ-018 SHALL, when flushW=1 and stallW=0 at a posedge, load a bubble: all W fields 0.
REQ-019 SHALL give stallW priority over flushW: when both are 1, the W register holds.
REQ-020 SHALL drive we3 = valid_w & reg_write_w & (wa_w != 0), combinationally from the W register.
REQ-021 SHALL drive wa3 = wa_w and pc_w = pc_w register.
REQ-022 SHALL drive wd3 = result_w when mem_to_reg_w=0; otherwise wd3 = extracted load data.
REQ-023 SHALL select the load byte lane with off = result_w[1:0].
  - LW: full word.
  - LH/LHU: halfword at off[1], sign- or zero-extended; off[0] is ignored (alignment faults are raised in MEM).
  - LB/LBU: byte at off, sign- or zero-extended.
REQ-024 SHALL capture a load that enters W and is then stalled, so its data stays stable across the stall.
  - A 1-bit held flag plus a 32-bit held-data register.
  - In the first W cycle with stallW=1, capture the extracted data and set held.
  - While held=1, wd3 uses the held data, not data_sram_rdata.
  - Clear held on any posedge with stallW=0.
REQ-025 SHALL give the pipeline zero added latency: data captured at edge N appears on wd3 in the cycle after edge N.
REQ-026 SHALL treat an undefined load_type with mem_to_reg_w=1 as LW.

Reset
REQ-027 SHALL, on rst=1 at a posedge, clear every W field and the held flag and data to 0, so that we3=0, wa3=0, wd3=0 and pc_w=0.
REQ-028 SHALL give rst priority over stallW and flushW.
REQ-029 SHALL, when rst is asserted mid-stall, discard the held load data.

Configuration
REQ-030 SHALL, when WB_DEBUG_TRACE_EN is defined, add these outputs:
  - debug_wb_pc[31:0] = pc_w.
  - debug_wb_rf_wen[3:0] = {4{we3 & ~stallW}}.
  - debug_wb_rf_wnum[4:0] = wa3.
  - debug_wb_rf_wdata[31:0] = wd3.
  - A 32-bit retired-instruction counter, output as debug_retired. It increments once per posedge with valid_w=1 and stallW=0, resets to 0 and wraps modulo 2^32.
REQ-031 SHALL, without WB_DEBUG_TRACE_EN, have none of these ports and no counter logic.

Structure
REQ-032 SHALL take the load_type encoding from the shared package cpu_defs_pkg: LT_LW=0, LT_LH=1, LT_LHU=2, LT_LB=3, LT_LBU=4.
REQ-033 SHALL implement byte and halfword extraction in a combinational sub-module load_extract (inputs rdata, off, load_type; output data).

Verification
REQ-034 SHALL pass: ALU op, result_m=0x0000_1234, wa_m=5, reg_write_m=1 -> next cycle we3=1, wa3=5, wd3=0x0000_1234.
REQ-035 SHALL pass: LB, off=3, rdata=0x80FF_FF7F -> wd3=0xFFFF_FF80; LBU same -> 0x0000_0080; LH, off=2 -> 0xFFFF_80FF; LHU -> 0x0000_80FF.
REQ-036 SHALL pass: LW enters W, stallW=1 for 3 cycles, rdata changes to 0xDEAD_BEEF after the first cycle -> wd3 holds the first-cycle value throughout.
REQ-037 SHALL pass: wa_m=0 with reg_write_m=1 -> we3=0; flushW=1 -> bubble with we3=0; stallW=flushW=1 -> W holds.
REQ-038 SHALL pass: rst asserted during a stalled load -> next cycle all outputs 0 and held cleared.
REQ-039 SHALL pass, with WB_DEBUG_TRACE_EN: 10 valid instructions with 2 stall cycles interleaved -> debug_retired=10; debug_wb_rf_wen=0 during stall cycles.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: load-type encoding, writeback register layout
// and the sign/zero extension helpers used by the load path.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  wa;
    logic [31:0] result;
    logic        mem_to_reg;
    logic [2:0]  load_type;
  } wb_reg_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_stage_load_extract.sv
// Combinational load lane selection and extension for the writeback stage.
// Unknown load types fall back to a full-word load.
module load_extract
  import cpu_defs_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lane depends only on off[1]; misalignment is trapped upstream.
  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (load_type)
      LT_LH:   data = ext16(half_sel, 1'b1);
      LT_LHU:  data = ext16(half_sel, 1'b0);
      LT_LB:   data = ext8(byte_sel, 1'b1);
      LT_LBU:  data = ext8(byte_sel, 1'b0);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage with stall/flush control and stall-safe load data.
// Optional trace/retire-counter outputs are enabled by WB_DEBUG_TRACE_EN.
module wb_stage
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallW,
  input  logic        flushW,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic        reg_write_m,
  input  logic [4:0]  wa_m,
  input  logic [31:0] result_m,
  input  logic        mem_to_reg_m,
  input  logic [2:0]  load_type_m,
  input  logic [31:0] data_sram_rdata,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [31:0] pc_w
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] debug_retired
`endif
);

  wb_reg_t     w_q;
  logic        held_q;
  logic [31:0] held_data_q;
  logic [31:0] load_data;

  load_extract u_load_extract (
    .rdata     (data_sram_rdata),
    .off       (w_q.result[1:0]),
    .load_type (w_q.load_type),
    .data      (load_data)
  );

  // SRAM data is only valid in the first W cycle, so a stalled load snapshots
  // its extracted value on the first stalled edge and replays it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      held_q      <= 1'b0;
      held_data_q <= '0;
    end else if (stallW) begin
      if (!held_q && w_q.mem_to_reg) begin
        held_q      <= 1'b1;
        held_data_q <= load_data;
      end
    end else begin
      held_q <= 1'b0;
      if (flushW) begin
        w_q <= '0;
      end else begin
        w_q.valid      <= valid_m;
        w_q.pc         <= pc_m;
        w_q.reg_write  <= reg_write_m;
        w_q.wa         <= wa_m;
        w_q.result     <= result_m;
        w_q.mem_to_reg <= mem_to_reg_m;
        w_q.load_type  <= load_type_m;
      end
    end
  end

  always_comb begin
    we3  = w_q.valid & w_q.reg_write & (w_q.wa != 5'd0);
    wa3  = w_q.wa;
    pc_w = w_q.pc;
    wd3  = w_q.result;
    if (w_q.mem_to_reg) begin
      wd3 = held_q ? held_data_q : load_data;
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (w_q.valid && !stallW) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign debug_wb_pc       = pc_w;
  assign debug_wb_rf_wen   = {4{we3 & ~stallW}};
  assign debug_wb_rf_wnum  = wa3;
  assign debug_wb_rf_wdata = wd3;
  assign debug_retired     = retired_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table for single-cycle behaviour
// plus directed stall, flush, reset and trace sequences.
module tb_wb_stage;
  import cpu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallW;
  logic        flushW;
  logic        valid_m;
  logic [31:0] pc_m;
  logic        reg_write_m;
  logic [4:0]  wa_m;
  logic [31:0] result_m;
  logic        mem_to_reg_m;
  logic [2:0]  load_type_m;
  logic [31:0] data_sram_rdata;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] pc_w;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] debug_retired;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stallW          (stallW),
    .flushW          (flushW),
    .valid_m         (valid_m),
    .pc_m            (pc_m),
    .reg_write_m     (reg_write_m),
    .wa_m            (wa_m),
    .result_m        (result_m),
    .mem_to_reg_m    (mem_to_reg_m),
    .load_type_m     (load_type_m),
    .data_sram_rdata (data_sram_rdata),
    .we3             (we3),
    .wa3             (wa3),
    .wd3             (wd3),
    .pc_w            (pc_w)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .debug_retired     (debug_retired)
`endif
  );

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] result;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] rdata;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveM(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] wa,
                        input logic [31:0] res, input logic m2r, input logic [2:0] lt);
    valid_m = v; pc_m = pc; reg_write_m = rw; wa_m = wa;
    result_m = res; mem_to_reg_m = m2r; load_type_m = lt;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveM(v.valid, v.pc, v.rw, v.wa, v.result, v.m2r, v.lt);
    stallW = 1'b0;
    flushW = v.flush;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string name, input logic ewe, input logic [4:0] ewa,
                          input logic [31:0] ewd, input logic [31:0] epc);
    checkOutput({name, ".we3"},  {31'd0, we3}, {31'd0, ewe});
    checkOutput({name, ".wa3"},  {27'd0, wa3}, {27'd0, ewa});
    checkOutput({name, ".wd3"},  wd3, ewd);
    checkOutput({name, ".pc_w"}, pc_w, epc);
  endtask

  initial begin
    //          flush valid pc            rw wa     result        m2r lt     rdata          we wa     wd             pc
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 3'd0,   32'h0BAD_F00D, 1'b1, 5'd5,  32'h0000_1234, 32'h0000_0100};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0104, 1'b1, 5'd7,  32'h0000_1003, 1'b1, LT_LB,  32'h80FF_FF7F, 1'b1, 5'd7,  32'hFFFF_FF80, 32'h0000_0104};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0108, 1'b1, 5'd7,  32'h0000_1003, 1'b1, LT_LBU, 32'h80FF_FF7F, 1'b1, 5'd7,  32'h0000_0080, 32'h0000_0108};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_010C, 1'b1, 5'd8,  32'h0000_1002, 1'b1, LT_LH,  32'h80FF_FF7F, 1'b1, 5'd8,  32'hFFFF_80FF, 32'h0000_010C};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0110, 1'b1, 5'd8,  32'h0000_1002, 1'b1, LT_LHU, 32'h80FF_FF7F, 1'b1, 5'd8,  32'h0000_80FF, 32'h0000_0110};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0114, 1'b1, 5'd9,  32'h0000_1003, 1'b1, LT_LH,  32'h80FF_FF7F, 1'b1, 5'd9,  32'hFFFF_80FF, 32'h0000_0114};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0118, 1'b1, 5'd10, 32'h0000_1000, 1'b1, LT_LB,  32'h80FF_FF7F, 1'b1, 5'd10, 32'h0000_007F, 32'h0000_0118};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_011C, 1'b1, 5'd11, 32'h0000_1001, 1'b1, LT_LBU, 32'h80FF_FF7F, 1'b1, 5'd11, 32'h0000_00FF, 32'h0000_011C};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0120, 1'b1, 5'd12, 32'h0000_1001, 1'b1, LT_LB,  32'h80FF_FF7F, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_0120};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0124, 1'b1, 5'd13, 32'h0000_1000, 1'b1, LT_LH,  32'h80FF_FF7F, 1'b1, 5'd13, 32'hFFFF_FF7F, 32'h0000_0124};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0128, 1'b1, 5'd14, 32'h0000_1000, 1'b1, LT_LHU, 32'h80FF_FF7F, 1'b1, 5'd14, 32'h0000_FF7F, 32'h0000_0128};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_012C, 1'b1, 5'd15, 32'h0000_1002, 1'b1, LT_LW,  32'h80FF_FF7F, 1'b1, 5'd15, 32'h80FF_FF7F, 32'h0000_012C};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0130, 1'b1, 5'd16, 32'h0000_1003, 1'b1, 3'd7,   32'h1234_5678, 1'b1, 5'd16, 32'h1234_5678, 32'h0000_0130};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0134, 1'b1, 5'd0,  32'h0000_5555, 1'b0, 3'd0,   32'h0,         1'b0, 5'd0,  32'h0000_5555, 32'h0000_0134};
    vecs[14] = '{1'b0, 1'b0, 32'h0000_0138, 1'b1, 5'd17, 32'h0000_6666, 1'b0, 3'd0,   32'h0,         1'b0, 5'd17, 32'h0000_6666, 32'h0000_0138};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_013C, 1'b0, 5'd18, 32'h0000_7777, 1'b0, 3'd0,   32'h0,         1'b0, 5'd18, 32'h0000_7777, 32'h0000_013C};
    vecs[16] = '{1'b1, 1'b1, 32'h0000_0140, 1'b1, 5'd19, 32'h0000_8888, 1'b0, 3'd0,   32'h0,         1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; stallW = 1'b0; flushW = 1'b0;
    driveM(1'b1, 32'hFFFF_FFF0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, LT_LW);
    data_sram_rdata = 32'hFFFF_FFFF;
    stepEdge();
    stepEdge();
    checkAll("reset", 1'b0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      stepEdge();
      data_sram_rdata = vecs[i].rdata;
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].ewa, vecs[i].ewd, vecs[i].epc);
    end

    // Stall and flush together must hold the W register.
    flushW = 1'b0;
    driveM(1'b1, 32'h0000_0200, 1'b1, 5'd9, 32'h0000_ABCD, 1'b0, LT_LW);
    stepEdge();
    driveM(1'b1, 32'h0000_0204, 1'b1, 5'd20, 32'h0000_1111, 1'b0, LT_LW);
    stallW = 1'b1; flushW = 1'b1;
    stepEdge();
    checkAll("stall_flush_hold", 1'b1, 5'd9, 32'h0000_ABCD, 32'h0000_0200);
    stallW = 1'b0; flushW = 1'b0;

    // Stalled LW keeps its first-cycle data even when the SRAM output moves.
    driveM(1'b1, 32'h0000_0300, 1'b1, 5'd3, 32'h0000_2000, 1'b1, LT_LW);
    stepEdge();
    data_sram_rdata = 32'h1122_3344;
    stallW = 1'b1;
    driveM(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, LT_LB);
    #1;
    checkAll("stall_c0", 1'b1, 5'd3, 32'h1122_3344, 32'h0000_0300);
    for (int k = 1; k < 3; k++) begin
      stepEdge();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      checkAll($sformatf("stall_c%0d", k), 1'b1, 5'd3, 32'h1122_3344, 32'h0000_0300);
    end
    stallW = 1'b0;
    driveM(1'b1, 32'h0000_0304, 1'b1, 5'd4, 32'h0000_2004, 1'b1, LT_LW);
    stepEdge();
    data_sram_rdata = 32'h5566_7788;
    #1;
    checkAll("after_stall_load", 1'b1, 5'd4, 32'h5566_7788, 32'h0000_0304);

    // Reset in the middle of a stalled load.
    driveM(1'b1, 32'h0000_0400, 1'b1, 5'd6, 32'h0000_2003, 1'b1, LT_LB);
    stepEdge();
    data_sram_rdata = 32'h8000_0000;
    stallW = 1'b1;
    #1;
    checkOutput("rst_stall_pre.wd3", wd3, 32'hFFFF_FF80);
    stepEdge();
    data_sram_rdata = 32'h0000_0000;
    rst = 1'b1;
    stepEdge();
    checkAll("rst_mid_stall", 1'b0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;
    stallW = 1'b0;

`ifdef WB_DEBUG_TRACE_EN
    rst = 1'b1;
    stepEdge();
    rst = 1'b0;
    checkOutput("dbg_retired_reset", debug_retired, 32'd0);
    for (int i = 0; i < 10; i++) begin
      driveM(1'b1, 32'h0000_0500 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 3), 1'b0, LT_LW);
      stallW = 1'b0;
      stepEdge();
      checkOutput($sformatf("dbg_wen_%0d", i), {28'd0, debug_wb_rf_wen}, 32'h0000_000F);
      checkOutput($sformatf("dbg_pc_%0d", i), debug_wb_pc, 32'h0000_0500 + 32'(4 * i));
      checkOutput($sformatf("dbg_wnum_%0d", i), {27'd0, debug_wb_rf_wnum}, 32'(i + 1));
      checkOutput($sformatf("dbg_wdata_%0d", i), debug_wb_rf_wdata, 32'(i * 3));
      if (i == 4) begin
        stallW = 1'b1;
        for (int s = 0; s < 2; s++) begin
          #1;
          checkOutput($sformatf("dbg_wen_stall%0d", s), {28'd0, debug_wb_rf_wen}, 32'h0);
          stepEdge();
        end
        checkOutput("dbg_retired_mid", debug_retired, 32'd4);
        stallW = 1'b0;
      end
    end
    driveM(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, LT_LW);
    stepEdge();
    checkOutput("dbg_retired_final", debug_retired, 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
